// File: rtl/wb_arbiter_2to1_if.sv
// Pipelined Wishbone port bundle: 32-bit address/data, 4-bit byte select.
// ERR is only present when WB_ARB_TIMEOUT_EN is defined.
interface wb_arbiter_2to1_if;
    logic        CYC;
    logic        STB;
    logic        WE;
    logic [31:0] ADR;
    logic [3:0]  SEL;
    logic [31:0] DAT_W;
    logic [31:0] DAT_R;
    logic        STALL;
    logic        ACK;
`ifdef WB_ARB_TIMEOUT_EN
    logic        ERR;

    modport master (output CYC, STB, WE, ADR, SEL, DAT_W,
                    input  DAT_R, STALL, ACK, ERR);
    modport slave  (input  CYC, STB, WE, ADR, SEL, DAT_W,
                    output DAT_R, STALL, ACK, ERR);
`else
    modport master (output CYC, STB, WE, ADR, SEL, DAT_W,
                    input  DAT_R, STALL, ACK);
    modport slave  (input  CYC, STB, WE, ADR, SEL, DAT_W,
                    output DAT_R, STALL, ACK);
`endif
endinterface

// File: rtl/wb_arbiter_2to1.sv
// Two-master round-robin arbiter for pipelined Wishbone, granting per CYC and
// capping in-flight requests. Optional ACK timeout/abort via WB_ARB_TIMEOUT_EN.
module wb_arbiter_2to1 #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT         = 16
) (
    input logic              CLK,
    input logic              RST,
    wb_arbiter_2to1_if.slave  m0,
    wb_arbiter_2to1_if.slave  m1,
    wb_arbiter_2to1_if.master s
);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt, wait_cnt_nx;
`else
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
`endif

    state_t        state, state_nx;
    logic          last_grant, last_grant_nx;
    logic [CW-1:0] out_cnt, out_cnt_nx;
    logic          own1;
    logic          below_cap;
    logic          cyc_k, stb_k, stb_o, stall_k, accept;

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        out_cnt_nx    = out_cnt;
        own1          = (state == OWN1);
        below_cap     = (out_cnt < CW'(MAX_OUTSTANDING));
        cyc_k         = own1 ? m1.CYC : m0.CYC;
        stb_k         = own1 ? m1.STB : m0.STB;
        stb_o         = 1'b0;
        stall_k       = 1'b1;
        accept        = 1'b0;

        s.CYC   = 1'b0;
        s.STB   = 1'b0;
        s.WE    = own1 ? m1.WE    : m0.WE;
        s.ADR   = own1 ? m1.ADR   : m0.ADR;
        s.SEL   = own1 ? m1.SEL   : m0.SEL;
        s.DAT_W = own1 ? m1.DAT_W : m0.DAT_W;

        m0.DAT_R = s.DAT_R;
        m1.DAT_R = s.DAT_R;
        m0.STALL = 1'b1;
        m1.STALL = 1'b1;
        m0.ACK   = 1'b0;
        m1.ACK   = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        m0.ERR      = 1'b0;
        m1.ERR      = 1'b0;
        wait_cnt_nx = '0;
`endif

        case (state)
            IDLE: begin
                out_cnt_nx = '0;
                if (m0.CYC && m1.CYC) begin
                    state_nx      = last_grant ? OWN0 : OWN1;
                    last_grant_nx = ~last_grant;
                end else if (m0.CYC) begin
                    state_nx      = OWN0;
                    last_grant_nx = 1'b0;
                end else if (m1.CYC) begin
                    state_nx      = OWN1;
                    last_grant_nx = 1'b1;
                end
            end

            OWN0, OWN1: begin
                stb_o   = cyc_k && stb_k && below_cap;
                stall_k = s.STALL || !below_cap;
                accept  = stb_o && !s.STALL;
                s.CYC   = cyc_k;
                s.STB   = stb_o;
                if (own1) begin
                    m1.STALL = stall_k;
                    m1.ACK   = s.ACK;
                end else begin
                    m0.STALL = stall_k;
                    m0.ACK   = s.ACK;
                end

                case ({accept, s.ACK})
                    2'b10:   out_cnt_nx = out_cnt + 1'b1;
                    2'b01:   out_cnt_nx = out_cnt - 1'b1;
                    default: out_cnt_nx = out_cnt;
                endcase

`ifdef WB_ARB_TIMEOUT_EN
                if (wait_cnt == TW'(TIMEOUT)) begin
                    if (own1) m1.ERR = 1'b1;
                    else      m0.ERR = 1'b1;
                    state_nx   = ABORT;
                    out_cnt_nx = '0;
                end else if (out_cnt != '0 && !stb_o && !s.ACK) begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
`endif
                // Owner dropping CYC is an abort: takes priority over everything else.
                if (!cyc_k) begin
                    state_nx   = IDLE;
                    out_cnt_nx = '0;
                end
            end

`ifdef WB_ARB_TIMEOUT_EN
            // last_grant still names the aborted owner; wait for it to drop CYC.
            ABORT: begin
                out_cnt_nx = '0;
                if (!(last_grant ? m1.CYC : m0.CYC)) state_nx = IDLE;
            end
`endif

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            out_cnt    <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            out_cnt    <= out_cnt_nx;
`ifdef WB_ARB_TIMEOUT_EN
            wait_cnt   <= wait_cnt_nx;
`endif
        end
    end

    ack_without_request: assert property (@(posedge CLK) disable iff (RST)
        !((state == OWN0 || state == OWN1) && s.ACK && out_cnt == '0));

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed scoreboard bench for wb_arbiter_2to1: expected slave requests and
// master ACKs are queued by the stimulus and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_wb_arbiter_2to1;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    wb_arbiter_2to1_if m0_bus();
    wb_arbiter_2to1_if m1_bus();
    wb_arbiter_2to1_if s_bus();

    wb_arbiter_2to1 #(.MAX_OUTSTANDING(4), .TIMEOUT(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .s   (s_bus)
    );

    typedef struct {
        int unsigned who;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } req_t;

    typedef struct {
        int unsigned who;
        logic [31:0] dat;
    } ack_t;

    req_t exp_req[$];
    ack_t exp_ack[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_mid();
        @(negedge CLK);
    endtask

    task automatic m0_drive(input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        m0_bus.CYC = cyc; m0_bus.STB = stb; m0_bus.WE = we;
        m0_bus.ADR = adr; m0_bus.SEL = sel; m0_bus.DAT_W = dat;
    endtask

    task automatic m1_drive(input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        m1_bus.CYC = cyc; m1_bus.STB = stb; m1_bus.WE = we;
        m1_bus.ADR = adr; m1_bus.SEL = sel; m1_bus.DAT_W = dat;
    endtask

    task automatic sl(input logic stall, input logic ack, input logic [31:0] dat);
        s_bus.STALL = stall; s_bus.ACK = ack; s_bus.DAT_R = dat;
    endtask

    task automatic push_req(input int unsigned who, input logic we, input logic [31:0] adr,
                            input logic [3:0] sel, input logic [31:0] dat);
        req_t r;
        r.who = who; r.we = we; r.adr = adr; r.sel = sel; r.dat = dat;
        exp_req.push_back(r);
    endtask

    task automatic push_ack(input int unsigned who, input logic [31:0] dat);
        ack_t a;
        a.who = who; a.dat = dat;
        exp_ack.push_back(a);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_cyc"},      s_bus.CYC,   1'b0);
        chk1({tag, "_stb"},      s_bus.STB,   1'b0);
        chk1({tag, "_m0_stall"}, m0_bus.STALL, 1'b1);
        chk1({tag, "_m1_stall"}, m1_bus.STALL, 1'b1);
        chk1({tag, "_m0_ack"},   m0_bus.ACK,  1'b0);
        chk1({tag, "_m1_ack"},   m1_bus.ACK,  1'b0);
`ifdef WB_ARB_TIMEOUT_EN
        chk1({tag, "_m0_err"},   m0_bus.ERR,  1'b0);
        chk1({tag, "_m1_err"},   m1_bus.ERR,  1'b0);
`endif
    endtask

    task automatic do_reset();
        step();
        RST = 1'b1;
        m0_drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        m1_drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        sl(1'b0, 1'b0, '0);
        at_mid();
        step();
        at_mid();
        check_reset_outputs("reset");
    endtask

    // Monitor: every accepted slave request and every master ACK is matched
    // against the head of its queue.
    initial begin
        req_t        r;
        ack_t        a;
        int unsigned who;
        forever begin
            at_mid();
            if (!RST) begin
                chk1("stb_implies_cyc", s_bus.STB && !s_bus.CYC, 1'b0);
                if (s_bus.CYC && s_bus.STB && !s_bus.STALL) begin
                    who = (m0_bus.STALL == 1'b0) ? 0 : ((m1_bus.STALL == 1'b0) ? 1 : 2);
                    if (exp_req.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_req: adr 0x%08h accepted, none expected at %0t",
                                 s_bus.ADR, $time);
                    end else begin
                        r = exp_req.pop_front();
                        chk("req_owner", who, r.who);
                        chk1("req_we", s_bus.WE, r.we);
                        chk("req_adr", s_bus.ADR, r.adr);
                        chk("req_sel", {28'd0, s_bus.SEL}, {28'd0, r.sel});
                        chk("req_dat", s_bus.DAT_W, r.dat);
                    end
                end
                if (m0_bus.ACK || m1_bus.ACK) begin
                    chk1("ack_one_hot", m0_bus.ACK && m1_bus.ACK, 1'b0);
                    who = m1_bus.ACK ? 1 : 0;
                    if (exp_ack.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_ack: m%0d acked, none expected at %0t", who, $time);
                    end else begin
                        a = exp_ack.pop_front();
                        chk("ack_owner", who, a.who);
                        chk("ack_dat", who == 1 ? m1_bus.DAT_R : m0_bus.DAT_R, a.dat);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n_err;
        int unsigned err_at;
        m0_drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        m1_drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        sl(1'b0, 1'b0, '0);
        do_reset();

        // Single write from m0.
        step(); RST = 1'b0;
        m0_drive(1'b1, 1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        push_req(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        at_mid();
        chk1("t1_first_stb_stalled", m0_bus.STALL, 1'b1);
        chk1("t1_idle_cyc", s_bus.CYC, 1'b0);
        step(); at_mid();
        chk1("t1_cyc", s_bus.CYC, 1'b1);
        chk1("t1_stb", s_bus.STB, 1'b1);
        chk("t1_adr", s_bus.ADR, 32'h100);
        chk1("t1_m0_stall", m0_bus.STALL, 1'b0);
        chk1("t1_m1_stall", m1_bus.STALL, 1'b1);
        step(); m0_bus.STB = 1'b0; sl(1'b0, 1'b1, 32'h0BADF00D); push_ack(0, 32'h0BADF00D);
        at_mid();
        chk1("t1_m0_ack", m0_bus.ACK, 1'b1);
        step(); sl(1'b0, 1'b0, '0); m0_bus.CYC = 1'b0;
        at_mid();
        chk1("t1_release_cyc", s_bus.CYC, 1'b0);
        step(); at_mid();
        chk1("t1_idle_after_stall", m0_bus.STALL, 1'b1);

        // Simultaneous requests: m0, m1, m0.
        do_reset();
        step(); RST = 1'b0;
        m0_drive(1'b1, 1'b1, 1'b0, 32'h200, 4'hF, '0);
        m1_drive(1'b1, 1'b1, 1'b0, 32'h300, 4'hF, '0);
        at_mid();
        chk1("t2_idle_m0_stall", m0_bus.STALL, 1'b1);
        chk1("t2_idle_m1_stall", m1_bus.STALL, 1'b1);
        step(); push_req(0, 1'b0, 32'h200, 4'hF, '0);
        at_mid();
        chk1("t2_m1_waits_a", m1_bus.STALL, 1'b1);
        step(); m0_bus.STB = 1'b0; sl(1'b0, 1'b1, 32'h11111111); push_ack(0, 32'h11111111);
        at_mid();
        chk1("t2_m1_waits_b", m1_bus.STALL, 1'b1);
        step(); sl(1'b0, 1'b0, '0); m0_bus.CYC = 1'b0;
        at_mid();
        chk1("t2_m1_waits_c", m1_bus.STALL, 1'b1);
        step(); m0_drive(1'b1, 1'b1, 1'b0, 32'h204, 4'hF, '0);
        at_mid();
        chk1("t2_gap_cyc", s_bus.CYC, 1'b0);
        step(); push_req(1, 1'b0, 32'h300, 4'hF, '0);
        at_mid();
        chk1("t2_m0_waits", m0_bus.STALL, 1'b1);
        step(); m1_bus.STB = 1'b0; sl(1'b0, 1'b1, 32'h22222222); push_ack(1, 32'h22222222);
        at_mid();
        step(); sl(1'b0, 1'b0, '0); m1_bus.CYC = 1'b0;
        at_mid();
        step(); m1_drive(1'b1, 1'b1, 1'b0, 32'h304, 4'hF, '0);
        at_mid();
        chk1("t2_gap2_cyc", s_bus.CYC, 1'b0);
        step(); push_req(0, 1'b0, 32'h204, 4'hF, '0);
        at_mid();
        chk1("t2_m1_waits_d", m1_bus.STALL, 1'b1);
        step(); m0_bus.STB = 1'b0; sl(1'b0, 1'b1, 32'h33333333); push_ack(0, 32'h33333333);
        at_mid();
        step(); sl(1'b0, 1'b0, '0);
        m0_drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        m1_drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        at_mid();

        // Outstanding cap: m1 issues 6 reads, no ACKs at first.
        step(); m1_drive(1'b1, 1'b1, 1'b0, 32'h400, 4'hF, '0);
        at_mid();
        for (int i = 0; i < 4; i++) begin
            step(); m1_bus.ADR = 32'h400 + 32'(4 * i);
            push_req(1, 1'b0, 32'h400 + 32'(4 * i), 4'hF, '0);
            at_mid();
            chk1("t3_accept_stall", m1_bus.STALL, 1'b0);
        end
        step(); m1_bus.ADR = 32'h410;
        at_mid();
        chk1("t3_cap_stb", s_bus.STB, 1'b0);
        chk1("t3_cap_stall", m1_bus.STALL, 1'b1);
        chk1("t3_cap_cyc", s_bus.CYC, 1'b1);
        step(); at_mid();
        chk1("t3_cap_stall2", m1_bus.STALL, 1'b1);
        step(); sl(1'b0, 1'b1, 32'h44444444); push_ack(1, 32'h44444444);
        at_mid();
        chk1("t3_cap_during_ack", s_bus.STB, 1'b0);
        step(); sl(1'b0, 1'b0, '0); push_req(1, 1'b0, 32'h410, 4'hF, '0);
        at_mid();
        chk1("t3_reenabled_stb", s_bus.STB, 1'b1);
        chk1("t3_reenabled_stall", m1_bus.STALL, 1'b0);
        step(); m1_bus.ADR = 32'h414;
        at_mid();
        chk1("t3_recap_stb", s_bus.STB, 1'b0);
        chk1("t3_recap_stall", m1_bus.STALL, 1'b1);
        step(); m1_drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        at_mid();
        chk1("t3_release_cyc", s_bus.CYC, 1'b0);

        // Slave stalls a write for 3 cycles.
        step(); sl(1'b1, 1'b0, '0);
        m0_drive(1'b1, 1'b1, 1'b1, 32'h500, 4'h3, 32'hCAFEF00D);
        at_mid();
        for (int i = 0; i < 3; i++) begin
            step(); at_mid();
            chk("t4_hold_adr", s_bus.ADR, 32'h500);
            chk("t4_hold_sel", {28'd0, s_bus.SEL}, 32'h3);
            chk1("t4_hold_we", s_bus.WE, 1'b1);
            chk("t4_hold_dat", s_bus.DAT_W, 32'hCAFEF00D);
            chk1("t4_hold_stb", s_bus.STB, 1'b1);
            chk1("t4_stall_mirror", m0_bus.STALL, 1'b1);
        end
        step(); sl(1'b0, 1'b0, '0); push_req(0, 1'b1, 32'h500, 4'h3, 32'hCAFEF00D);
        at_mid();
        chk1("t4_unstalled", m0_bus.STALL, 1'b0);
        step(); m0_bus.STB = 1'b0; sl(1'b0, 1'b1, 32'h55555555); push_ack(0, 32'h55555555);
        at_mid();

        // Same ownership: 4 more reads must all fit, so stalled beats were not counted.
        step(); sl(1'b0, 1'b0, '0);
        m0_drive(1'b1, 1'b1, 1'b0, 32'h600, 4'hF, '0);
        push_req(0, 1'b0, 32'h600, 4'hF, '0);
        at_mid();
        chk1("t4_count_a", m0_bus.STALL, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step(); m0_bus.ADR = 32'h600 + 32'(4 * i);
            push_req(0, 1'b0, 32'h600 + 32'(4 * i), 4'hF, '0);
            at_mid();
            chk1("t4_count_b", m0_bus.STALL, 1'b0);
        end
        step(); m0_bus.ADR = 32'h610;
        at_mid();
        chk1("t4_count_cap", m0_bus.STALL, 1'b1);
        step(); m0_bus.STB = 1'b0; sl(1'b0, 1'b1, 32'h66666666); push_ack(0, 32'h66666666);
        at_mid();
        step(); sl(1'b0, 1'b1, 32'h77777777); push_ack(0, 32'h77777777);
        at_mid();

        // Drop CYC with 2 outstanding; the late ACK must be swallowed.
        step(); sl(1'b0, 1'b0, '0); m0_bus.CYC = 1'b0;
        at_mid();
        chk1("t5_abort_cyc", s_bus.CYC, 1'b0);
        step(); sl(1'b0, 1'b1, 32'h88888888);
        at_mid();
        chk1("t5_late_ack_m0", m0_bus.ACK, 1'b0);
        chk1("t5_late_ack_m1", m1_bus.ACK, 1'b0);
        step(); sl(1'b0, 1'b0, '0);
        m0_drive(1'b1, 1'b1, 1'b0, 32'h700, 4'hF, '0);
        at_mid();
        for (int i = 0; i < 4; i++) begin
            step(); m0_bus.ADR = 32'h700 + 32'(4 * i);
            push_req(0, 1'b0, 32'h700 + 32'(4 * i), 4'hF, '0);
            at_mid();
            chk1("t5_cnt_cleared", m0_bus.STALL, 1'b0);
        end
        step(); m0_bus.ADR = 32'h710;
        at_mid();
        chk1("t5_cap_again", m0_bus.STALL, 1'b1);

        // Reset while m0 still holds CYC.
        step(); RST = 1'b1;
        at_mid();
        chk1("t6_cyc_before_edge", s_bus.CYC, 1'b1);
        step(); at_mid();
        chk1("t6_cyc_after_reset", s_bus.CYC, 1'b0);
        chk1("t6_stall_after_reset", m0_bus.STALL, 1'b1);
        step(); RST = 1'b0; m0_drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        at_mid();

`ifdef WB_ARB_TIMEOUT_EN
        // Unacked read: ERR expected on the 17th negedge after the accepting one,
        // i.e. in the cycle that starts 16 edges after the acceptance edge.
        step(); m0_drive(1'b1, 1'b1, 1'b0, 32'h800, 4'hF, '0);
        at_mid();
        step(); push_req(0, 1'b0, 32'h800, 4'hF, '0);
        at_mid();
        n_err  = 0;
        err_at = 0;
        step(); m0_bus.STB = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            if (c > 1) step();
            at_mid();
            if (m0_bus.ERR === 1'b1) begin
                n_err++;
                if (err_at == 0) err_at = c;
            end
            if (m1_bus.ERR !== 1'b0) chk1("to_m1_err", m1_bus.ERR, 1'b0);
        end
        chk("to_err_pulses", n_err, 1);
        chk("to_err_cycle", err_at, 17);
        chk1("to_abort_cyc", s_bus.CYC, 1'b0);
        chk1("to_abort_stall", m0_bus.STALL, 1'b1);
        step(); m0_drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        at_mid();
        step(); m0_drive(1'b1, 1'b1, 1'b0, 32'h900, 4'hF, '0);
        at_mid();
        chk1("to_idle_cyc", s_bus.CYC, 1'b0);
        step(); push_req(0, 1'b0, 32'h900, 4'hF, '0);
        at_mid();
        chk1("to_regrant", m0_bus.STALL, 1'b0);
        step(); m0_drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        at_mid();
`endif

        step(); at_mid();
        chk("req_queue_drained", exp_req.size(), 0);
        chk("ack_queue_drained", exp_ack.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
